dmac_mc_datapath: RTL

Parametrised multi-channel DMAC datapath. It arbitrates among NUM_CH peripheral requests and fetches a three-word descriptor for the granted channel from that channel's peripheral space. It then runs the transfer as single-beat AHB read/write pairs through one shared master port, and signals completion or error per channel. Only one channel is serviced at a time. It sits between the request lines and the AHB master interface, replacing the fixed two-channel datapath.

---
 rtl/dmac_mc_pkg.sv | 42 ++++
 rtl/dmac_mc_datapath_if.sv | 25 ++
 rtl/dmac_mc_arbiter.sv | 63 ++++++
 rtl/dmac_mc_datapath.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dmac_mc_pkg.sv
// Shared types and constants for the multi-channel DMAC datapath.
// Optional round-robin arbitration is enabled with DMAC_RR_ARB_EN.
package dmac_mc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG_A,
        ST_CFG_D,
        ST_RD_A,
        ST_RD_D,
        ST_WR_A,
        ST_WR_D,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [1:0] HSIZE_WORD    = 2'b10;

    localparam logic [31:0] OFF_DADDR = 32'h0000_0300;
    localparam logic [31:0] OFF_SIZE  = 32'h0000_0304;
    localparam logic [31:0] OFF_CTRL  = 32'h0000_0308;

    localparam int CTRL_HSIZE_LSB = 4;
    localparam int CTRL_SRC_FIXED = 6;
    localparam int CTRL_DST_FIXED = 7;

    // Byte lanes touched by a write of the given size at the given address.
    function automatic logic [3:0] wstrb(input logic [1:0] hsize,
                                         input logic [1:0] lsb);
        logic [3:0] s;
        unique case (hsize)
            2'b00:   s = 4'b0001 << lsb;
            2'b01:   s = 4'b0011 << {lsb[1], 1'b0};
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dmac_mc_datapath_if.sv
// AHB master bus bundle between the DMAC datapath and the system bus.
// Optional round-robin arbitration is enabled with DMAC_RR_ARB_EN.
interface dmac_mc_datapath_if;

    logic        HReady;
    logic [1:0]  M_HResp;
    logic [31:0] MRData;
    logic [31:0] MAddress;
    logic [31:0] MWData;
    logic [1:0]  MTrans;
    logic        MWrite;
    logic [1:0]  MSize;
    logic [3:0]  MWStrb;

    modport master (
        input  HReady, M_HResp, MRData,
        output MAddress, MWData, MTrans, MWrite, MSize, MWStrb
    );

    modport slave (
        output HReady, M_HResp, MRData,
        input  MAddress, MWData, MTrans, MWrite, MSize, MWStrb
    );

endinterface

// File: rtl/dmac_mc_arbiter.sv
// Channel arbiter: fixed lowest-index priority by default,
// round-robin from last grant when DMAC_RR_ARB_EN is defined.
module dmac_mc_arbiter
    import dmac_mc_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CW = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              en_i,
    output logic              grant_valid_o,
    output logic [CW-1:0]     grant_idx_o
);

`ifdef DMAC_RR_ARB_EN
    logic [CW-1:0] last_q;
    int            pos;
    logic [CW-1:0] pos_c;

    // Scan from last_q+1 with wrap; descending loop leaves the nearest winner.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        pos           = 0;
        pos_c         = '0;
        for (int j = NUM_CH; j >= 1; j--) begin
            pos   = (int'(last_q) + j) % NUM_CH;
            pos_c = CW'(pos);
            if (req_i[pos_c]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = pos_c;
            end
        end
    end

    // Remember the last channel actually granted from IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= CW'(NUM_CH - 1);
        end else if (en_i && grant_valid_o) begin
            last_q <= grant_idx_o;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = clk ^ rst ^ en_i;

    // Lowest requesting index wins; descending loop leaves it last.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_i[CW'(i)]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = CW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/dmac_mc_datapath.sv
// Multi-channel DMAC datapath: descriptor fetch and single-beat copy.
// Optional round-robin arbitration is enabled with DMAC_RR_ARB_EN.
module dmac_mc_datapath
    import dmac_mc_pkg::*;
#(
    parameter int          NUM_CH        = 4,
    parameter logic [31:0] PERIPH_BASE   = 32'h0000_0000,
    parameter logic [31:0] PERIPH_STRIDE = 32'h0000_1000,
    localparam int CW = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   DmacReq,
    dmac_mc_datapath_if.master  bus,
    output logic                busy,
    output logic [CW-1:0]       active_ch,
    output logic [NUM_CH-1:0]   irq,
    output logic [NUM_CH-1:0]   err_status
);

    state_e            state_q;
    logic [1:0]        k_q;
    logic [CW-1:0]     ch_q;
    logic [31:0]       base_q;
    logic [31:0]       saddr_q;
    logic [31:0]       daddr_q;
    logic [31:0]       size_q;
    logic [1:0]        hsize_q;
    logic              sfix_q;
    logic              dfix_q;
    logic [31:0]       data_q;
    logic [NUM_CH-1:0] err_q;
    logic [NUM_CH-1:0] armed_q;

    logic              gnt_v;
    logic [CW-1:0]     gnt_idx;
    logic [31:0]       gnt_base;
    logic [31:0]       step;
    logic              resp_err;

    assign gnt_base = PERIPH_BASE + PERIPH_STRIDE * 32'(gnt_idx);
    assign step     = 32'd1 << hsize_q;
    assign resp_err = (bus.M_HResp == HRESP_ERROR);

    dmac_mc_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk          (clk),
        .rst          (rst),
        .req_i        (DmacReq & armed_q),
        .en_i         (state_q == ST_IDLE),
        .grant_valid_o(gnt_v),
        .grant_idx_o  (gnt_idx)
    );

    // Channel sequencer: descriptor fetch, read/write beats, completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            ch_q    <= '0;
            base_q  <= '0;
            saddr_q <= '0;
            daddr_q <= '0;
            size_q  <= '0;
            hsize_q <= '0;
            sfix_q  <= 1'b0;
            dfix_q  <= 1'b0;
            data_q  <= '0;
            err_q   <= '0;
            armed_q <= '1;
        end else begin
            armed_q <= armed_q | ~DmacReq;
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_v) begin
                        ch_q          <= gnt_idx;
                        base_q        <= gnt_base;
                        saddr_q       <= gnt_base;
                        err_q[gnt_idx] <= 1'b0;
                        k_q           <= '0;
                        state_q       <= ST_CFG_A;
                    end
                end
                ST_CFG_A: if (bus.HReady) state_q <= ST_CFG_D;
                ST_CFG_D: begin
                    if (resp_err) begin
                        state_q <= ST_ERR;
                    end else if (bus.HReady) begin
                        if (k_q != 2'd2) begin
                            if (k_q == 2'd0) daddr_q <= bus.MRData;
                            else             size_q  <= bus.MRData;
                            k_q     <= k_q + 2'd1;
                            state_q <= ST_CFG_A;
                        end else begin
                            hsize_q <= bus.MRData[CTRL_HSIZE_LSB +: 2];
                            sfix_q  <= bus.MRData[CTRL_SRC_FIXED];
                            dfix_q  <= bus.MRData[CTRL_DST_FIXED];
                            if (size_q == 32'd0)
                                state_q <= ST_DONE;
                            else if (bus.MRData[CTRL_HSIZE_LSB +: 2] == 2'b11)
                                state_q <= ST_ERR;
                            else
                                state_q <= ST_RD_A;
                        end
                    end
                end
                ST_RD_A: if (bus.HReady) state_q <= ST_RD_D;
                ST_RD_D: begin
                    if (resp_err) begin
                        state_q <= ST_ERR;
                    end else if (bus.HReady) begin
                        data_q  <= bus.MRData;
                        state_q <= ST_WR_A;
                    end
                end
                ST_WR_A: if (bus.HReady) state_q <= ST_WR_D;
                ST_WR_D: begin
                    if (resp_err) begin
                        state_q <= ST_ERR;
                    end else if (bus.HReady) begin
                        size_q <= size_q - 32'd1;
                        if (!sfix_q) saddr_q <= saddr_q + step;
                        if (!dfix_q) daddr_q <= daddr_q + step;
                        state_q <= (size_q == 32'd1) ? ST_DONE : ST_RD_A;
                    end
                end
                ST_DONE: begin
                    armed_q[ch_q] <= ~DmacReq[ch_q];
                    state_q       <= ST_IDLE;
                end
                ST_ERR: begin
                    armed_q[ch_q] <= ~DmacReq[ch_q];
                    err_q[ch_q]   <= 1'b1;
                    state_q       <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Per-channel completion pulse while in a terminal state.
    always_comb begin
        irq = '0;
        if (state_q == ST_DONE || state_q == ST_ERR) irq[ch_q] = 1'b1;
    end

    // Bus address and size decoded from the registered state.
    always_comb begin
        bus.MAddress = '0;
        bus.MSize    = '0;
        unique case (1'b1)
            (state_q == ST_CFG_A || state_q == ST_CFG_D): begin
                bus.MAddress = base_q + OFF_DADDR + {28'h0, k_q, 2'b00};
                bus.MSize    = HSIZE_WORD;
            end
            (state_q == ST_RD_A || state_q == ST_RD_D): begin
                bus.MAddress = saddr_q;
                bus.MSize    = hsize_q;
            end
            (state_q == ST_WR_A || state_q == ST_WR_D): begin
                bus.MAddress = daddr_q;
                bus.MSize    = hsize_q;
            end
            default: ;
        endcase
    end

    assign bus.MTrans = (state_q == ST_CFG_A || state_q == ST_RD_A ||
                         state_q == ST_WR_A) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.MWrite = (state_q == ST_WR_A || state_q == ST_WR_D);
    assign bus.MWStrb = bus.MWrite ? wstrb(hsize_q, daddr_q[1:0]) : 4'b0000;
    assign bus.MWData = data_q;

    assign busy       = (state_q != ST_IDLE);
    assign active_ch  = ch_q;
    assign err_status = err_q;

endmodule
